// File: rtl/pcm_sdm_dac.sv
// First-order sigma-delta DAC for the 19-bit PCM stream.
// It has a one-deep valid/ready input buffer, OSR-cycle sample slots and a saturating underrun counter.
module pcm_sdm_dac #(
  parameter int unsigned OSR = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [18:0] pcm_data,
  input  logic        pcm_valid,
  output logic        pcm_ready,
  output logic        dac_out,
  output logic [7:0]  underrun_count
);

  localparam int unsigned DW = 19;
  localparam int unsigned CW = 8;
  localparam int unsigned PW = (OSR > 1) ? $clog2(OSR) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   cur_q, cur_d;
  logic [DW-1:0]   nxt_q, nxt_d;
  logic            nxt_full_q, nxt_full_d;
  logic            dac_q, dac_d;
  logic            ready_q, ready_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [DW-1:0]   u_c;
  logic [DW:0]     sum_c;
  logic            boundary_c;
  logic            xfer_c;

  // Offset-binary sample added into the wrapping accumulator; the carry is the output bit.
  assign u_c        = {~cur_q[DW-1], cur_q[DW-2:0]};
  assign sum_c      = {1'b0, acc_q} + {1'b0, u_c};
  assign boundary_c = (phase_q == PW'(OSR - 1));
  assign xfer_c     = pcm_valid && ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      acc_q      <= '0;
      cur_q      <= '0;
      nxt_q      <= '0;
      nxt_full_q <= 1'b0;
      dac_q      <= 1'b0;
      ready_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      nxt_full_q <= nxt_full_d;
      dac_q      <= dac_d;
      ready_q    <= ready_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = enable ? RUN : IDLE;
    phase_d    = phase_q;
    acc_d      = acc_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    nxt_full_d = nxt_full_q;
    dac_d      = dac_q;
    cnt_d      = cnt_q;

    if (state_q == RUN && enable) begin
      acc_d   = sum_c[DW-1:0];
      dac_d   = sum_c[DW];
      phase_d = phase_q + PW'(1);
      if (boundary_c) begin
        if (nxt_full_q) begin
          cur_d      = nxt_q;
          nxt_full_d = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // A transfer is only possible with the buffer empty, so it never races a consume.
      if (xfer_c) begin
        nxt_d      = pcm_data;
        nxt_full_d = 1'b1;
      end
    end else begin
      // Muted: everything returns to its reset value except the underrun count.
      phase_d    = '0;
      acc_d      = '0;
      cur_d      = '0;
      nxt_d      = '0;
      nxt_full_d = 1'b0;
      dac_d      = 1'b0;
    end

    ready_d = (state_d == RUN) && !nxt_full_d;
  end

  assign pcm_ready      = ready_q;
  assign dac_out        = dac_q;
  assign underrun_count = cnt_q;

endmodule

// File: doc/pcm_sdm_dac.md
# pcm_sdm_dac

First-order sigma-delta DAC that consumes the 19-bit PCM stream produced by the delay/echo stage and drives a single-bit pin that an external RC filter turns into audio. Samples arrive through a one-deep valid/ready buffer, are held for OSR clock cycles each, and are noise-shaped into a 1-bit density-modulated output. If the upstream stage misses a sample slot, the block repeats the last sample and counts the underrun.

## Interface

Parameters:

- `OSR`, default 64: clocks per PCM sample. It is a power of two, ≥ 2. The phase counter is `$clog2(OSR)` bits.

Ports (all synchronous to `clk`):

- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `enable`  input  1  run/mute control.
- `pcm_data`  input  19  two's-complement PCM sample.
- `pcm_valid`  input  1  `pcm_data` is valid this cycle.
- `pcm_ready`  output  1  the block can accept a sample this cycle.
- `dac_out`  output  1  registered sigma-delta bitstream.
- `underrun_count`  output  8  saturating count of missed sample slots.

## Operation

- **Reset values** (one cycle of `rst` high):
  - `acc`=0, `phase`=0, `cur`=0 (midscale), `nxt`=0, `nxt_full`=0.
  - Outputs: `dac_out`=0, `pcm_ready`=0, `underrun_count`=0.
  - `rst` overrides every other input, including mid-sample.
- **State machine**, two states:
  - IDLE: `enable`=0. This is the state after reset.
  - RUN: `enable`=1.
  - IDLE→RUN on the first cycle that `enable`=1 while `rst`=0.
  - RUN→IDLE on any cycle that `enable`=0.
  - Every cycle spent in IDLE applies the reset values to all state except `underrun_count`, which holds.
- **Input buffer** (RUN only):
  - `pcm_ready` = RUN && !`nxt_full`. It is registered-state-derived with no combinational path from `pcm_valid`.
  - A transfer occurs when `pcm_valid` && `pcm_ready`: `nxt`<=`pcm_data`, `nxt_full`<=1.
  - `pcm_data` is ignored when no transfer occurs.
- **Phase counter**:
  - `phase` increments every RUN cycle and wraps from OSR-1 to 0.
  - The cycle with `phase`==OSR-1 is the sample boundary.
- **At a boundary**:
  - If `nxt_full`=1: `cur`<=`nxt`, `nxt_full`<=0.
  - If `nxt_full`=0: `cur` is held, and `underrun_count` increments, saturating at 255.
  - Simultaneous boundary and transfer can only happen with `nxt_full`=0. It counts as an underrun, and the new sample lands in `nxt`.
- **Modulator arithmetic**, every RUN cycle:
  - `u` = {~`cur`[18], `cur`[17:0]}, i.e. offset binary, `cur` + 2^18.
  - `sum` = {1'b0,`acc`} + {1'b0,`u`}, 20 bits.
  - `acc` <= `sum`[18:0], and `dac_out` <= `sum`[19].
  - There is no saturation anywhere: the 19-bit wrap of `acc` is the modulator.
- **Output density**: the long-run ones density of `dac_out` equals `u`/2^19.
  - `cur` = -262144 (0x40000) gives constant 0.
  - `cur` = 0 gives 0,1,0,1… starting from `acc`=0.

## Timing

- `dac_out` is registered. The bit computed from `cur` in cycle n appears in cycle n+1.
- `cur` loads at the boundary clock edge. The first `dac_out` bit using the new sample appears 2 cycles after the boundary cycle.
- **Latency**: a sample transferred in cycle t enters `cur` at the next boundary at or after t+1. Worst case is OSR+1 cycles of buffering.
- Throughput is exactly one sample per OSR cycles. The buffer allows upstream up to OSR-1 cycles of slack per sample.
- **Deasserting `enable`**:
  - `dac_out` reads 0 starting in the next cycle.
  - Any buffered sample is discarded.
  - `pcm_ready` is 0 in the next cycle.
- **Re-enabling**: `phase` restarts at 0, `cur` is midscale, and the first boundary is OSR cycles after the first RUN cycle.
- `pcm_ready` rises in the first RUN cycle. Within a run, it rises in the cycle after the boundary edge that consumed `nxt`.

## Test plan

1. **Reset and midscale.**
   - Stimulus: assert `rst`, then `enable`=1 with `pcm_valid`=0.
   - Required: `dac_out`=0 and `underrun_count`=0 during reset. After reset, `dac_out` reads 0,1,0,1…, and `underrun_count` increments once per 64 cycles.
2. **Full-scale positive.**
   - Stimulus: feed 0x3FFFF every slot.
   - Required: the steady-state per-64-cycle window contains 64 ones, except windows spanning an `acc` wrap, which contain 63. The density converges to (2^19-1)/2^19.
3. **Full-scale negative and ramp.**
   - Stimulus: feed 0x40000, then step to 0x20000 (+2^17).
   - Required: `dac_out` stays 0 while the 0x40000 sample is active. Over the second sample's window it settles to a density of 3/4: 48 ones per 64 cycles once `acc` aligns.
4. **Backpressure.**
   - Stimulus: hold `pcm_valid`=1 with incrementing data.
   - Required: `pcm_ready` is high for exactly one cycle per OSR period after the first fill. No sample is dropped or duplicated: checked via a scoreboard of `cur` loads. `underrun_count` stays 0.
5. **Underrun saturation and simultaneity.**
   - Stimulus: present `pcm_valid` only on the boundary cycle with `nxt_full`=0. Separately, starve the input for 300 slots.
   - Required: in the first case the count increments and the sample is used at the following boundary. In the second, the count stops at 255.
6. **Enable and reset mid-sample.**
   - Stimulus: drop `enable` at `phase`=30 with `nxt_full`=1, then re-enable.
   - Required: `dac_out`=0 next cycle, and the buffered sample is lost. The first boundary falls 64 cycles after re-enable, and `underrun_count` is preserved. Repeating the sequence with `rst` instead clears the count.
